view_compositor: RTL

Parametrised successor to the fixed three-pane VGA mux in the top level. It accepts `NUM_VIEWS` pixel streams, each from a view module such as the track, racer or forward renderer, and gives each one a runtime-programmable screen rectangle. Overlaps are resolved by fixed priority. Hsync, vsync and blank are delayed to match the pixel data, and the block drives the 12-bit VGA pins directly. Layout writes arrive from the game/ethernet control logic and take effect only at frame boundaries, so the screen never tears.

---
 rtl/kart_video_pkg.sv | 34 +++
 rtl/view_window_hit.sv | 15 +
 rtl/view_compositor.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/kart_video_pkg.sv
// Shared video types for the kart display path: counter widths, pixel type,
// per-view window descriptor and the boot-time three-pane layout.
package kart_video_pkg;

  localparam int HCOUNT_W = 11;
  localparam int VCOUNT_W = 10;

  typedef logic [11:0] pixel_t;

  typedef struct packed {
    logic [HCOUNT_W-1:0] x0;
    logic [HCOUNT_W-1:0] x1;
    logic [VCOUNT_W-1:0] y0;
    logic [VCOUNT_W-1:0] y1;
    logic                en;
  } view_win_t;

  // track left, racer top-right, forward view bottom-right
  localparam view_win_t DEFAULT_WIN [3] = '{
    '{x0: 11'd0,   x1: 11'd512,  y0: 10'd0,   y1: 10'd512, en: 1'b1},
    '{x0: 11'd512, x1: 11'd1024, y0: 10'd0,   y1: 10'd384, en: 1'b1},
    '{x0: 11'd512, x1: 11'd1024, y0: 10'd384, y1: 10'd768, en: 1'b1}
  };

  function automatic view_win_t reset_win(input int idx);
    case (idx)
      0:       return DEFAULT_WIN[0];
      1:       return DEFAULT_WIN[1];
      2:       return DEFAULT_WIN[2];
      default: return '0;
    endcase
  endfunction

endpackage

// File: rtl/view_window_hit.sv
// Half-open rectangle test for one view window; degenerate windows
// (x1 <= x0 or y1 <= y0) fall out of the compares and never hit.
module view_window_hit
  import kart_video_pkg::*;
(
  input  view_win_t           win,
  input  logic [HCOUNT_W-1:0] h,
  input  logic [VCOUNT_W-1:0] v,
  output logic                hit
);

  assign hit = win.en && (h >= win.x0) && (h < win.x1) &&
               (v >= win.y0) && (v < win.y1);

endmodule

// File: rtl/view_compositor.sv
// Multi-view VGA compositor: per-view windows double-buffered and swapped on
// the vsync rising edge, fixed lowest-index priority, timing delayed to match.
module view_compositor
  import kart_video_pkg::*;
#(
  parameter int                 NUM_VIEWS   = 3,
  parameter int                 SRC_LATENCY = 5,
  parameter int                 PIXEL_W     = 12,
  parameter logic [PIXEL_W-1:0] BG_COLOR    = 12'h000,
  localparam int                CFG_W       = (NUM_VIEWS > 1) ? $clog2(NUM_VIEWS) : 1
) (
  input  logic                           clk_in,
  input  logic                           rst_in,
  input  logic [HCOUNT_W-1:0]            hcount_in,
  input  logic [VCOUNT_W-1:0]            vcount_in,
  input  logic                           hsync_in,
  input  logic                           vsync_in,
  input  logic                           blank_in,
  input  logic [NUM_VIEWS*PIXEL_W-1:0]   pixel_in,
  input  logic                           cfg_valid_in,
  input  logic [CFG_W-1:0]               cfg_view_in,
  input  logic [HCOUNT_W-1:0]            cfg_x0_in,
  input  logic [HCOUNT_W-1:0]            cfg_x1_in,
  input  logic [VCOUNT_W-1:0]            cfg_y0_in,
  input  logic [VCOUNT_W-1:0]            cfg_y1_in,
  input  logic                           cfg_en_in,
  output logic [3:0]                     vga_r,
  output logic [3:0]                     vga_g,
  output logic [3:0]                     vga_b,
  output logic                           vga_hs,
  output logic                           vga_vs,
  output logic                           frame_commit_out
);

  logic [HCOUNT_W-1:0]  h_dly [SRC_LATENCY];
  logic [VCOUNT_W-1:0]  v_dly [SRC_LATENCY];
  logic [SRC_LATENCY-1:0] hs_dly;
  logic [SRC_LATENCY-1:0] vs_dly;
  logic [SRC_LATENCY-1:0] bl_dly;

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      for (int i = 0; i < SRC_LATENCY; i++) begin
        h_dly[i] <= '0;
        v_dly[i] <= '0;
      end
      hs_dly <= '0;
      vs_dly <= '0;
      bl_dly <= '0;
    end else begin
      h_dly[0]  <= hcount_in;
      v_dly[0]  <= vcount_in;
      hs_dly[0] <= hsync_in;
      vs_dly[0] <= vsync_in;
      bl_dly[0] <= blank_in;
      for (int i = 1; i < SRC_LATENCY; i++) begin
        h_dly[i]  <= h_dly[i-1];
        v_dly[i]  <= v_dly[i-1];
        hs_dly[i] <= hs_dly[i-1];
        vs_dly[i] <= vs_dly[i-1];
        bl_dly[i] <= bl_dly[i-1];
      end
    end
  end

  view_win_t pending [NUM_VIEWS];
  view_win_t active  [NUM_VIEWS];
  view_win_t cfg_win;
  logic      vsync_prev;
  logic      commit;

  assign commit  = vsync_in && !vsync_prev;
  assign cfg_win = '{x0: cfg_x0_in, x1: cfg_x1_in, y0: cfg_y0_in, y1: cfg_y1_in, en: cfg_en_in};

  // a write landing on the commit edge goes to pending only; active takes the old pending
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      for (int i = 0; i < NUM_VIEWS; i++) begin
        pending[i] <= reset_win(i);
        active[i]  <= reset_win(i);
      end
      vsync_prev       <= 1'b0;
      frame_commit_out <= 1'b0;
    end else begin
      vsync_prev       <= vsync_in;
      frame_commit_out <= commit;
      for (int i = 0; i < NUM_VIEWS; i++) begin
        if (commit)
          active[i] <= pending[i];
        if (cfg_valid_in && (cfg_view_in == CFG_W'(i)))
          pending[i] <= cfg_win;
      end
    end
  end

  logic [NUM_VIEWS-1:0] hit_comb;

  for (genvar gi = 0; gi < NUM_VIEWS; gi++) begin : g_hit
    view_window_hit u_hit (
      .win (active[gi]),
      .h   (h_dly[SRC_LATENCY-1]),
      .v   (v_dly[SRC_LATENCY-1]),
      .hit (hit_comb[gi])
    );
  end

  logic [NUM_VIEWS-1:0]         hit_b;
  logic [NUM_VIEWS*PIXEL_W-1:0] pix_b;
  logic                         hs_b;
  logic                         vs_b;
  logic                         bl_b;

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      hit_b <= '0;
      pix_b <= '0;
      hs_b  <= 1'b0;
      vs_b  <= 1'b0;
      bl_b  <= 1'b0;
    end else begin
      hit_b <= hit_comb;
      pix_b <= pixel_in;
      hs_b  <= hs_dly[SRC_LATENCY-1];
      vs_b  <= vs_dly[SRC_LATENCY-1];
      bl_b  <= bl_dly[SRC_LATENCY-1];
    end
  end

  logic [PIXEL_W-1:0] color_sel;
  logic [PIXEL_W-1:0] color_c;

  // scan high to low so the lowest hitting index overwrites last
  always_comb begin
    color_sel = BG_COLOR;
    for (int i = NUM_VIEWS - 1; i >= 0; i--) begin
      if (hit_b[i])
        color_sel = pix_b[i*PIXEL_W +: PIXEL_W];
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      color_c <= '0;
      vga_hs  <= 1'b1;
      vga_vs  <= 1'b1;
    end else begin
      color_c <= bl_b ? '0 : color_sel;
      vga_hs  <= ~hs_b;
      vga_vs  <= ~vs_b;
    end
  end

  assign vga_r = color_c[11:8];
  assign vga_g = color_c[7:4];
  assign vga_b = color_c[3:0];

endmodule
